// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control sequencer: FSM state encoding,
// default drain length and the control word loaded into a bubbled latch.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrlState_e;

    // ID/EX, EX/MEM and MEM/WB must empty after HLT leaves IF/ID
    localparam int DRAIN_CYCLES_DEF = 3;

    // Control bits written into ID/EX when a bubble is inserted
    localparam logic [7:0] NOP_CTRL = 8'h00;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the optional performance counters.
// Clears on rst, sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count qualifying cycles, holding at the maximum value
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= {CNT_W{1'b0}};
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control sequencer for the 5-stage pipeline. Turns hazard stalls,
// branch redirects, cache-miss busy flags and HLT into latch write enables,
// IF/ID flush, ID/EX bubble insert and a halt-drain sequence.
// Optional feature macro: PIPE_CTRL_PERF_EN adds saturating stall/flush
// performance counters (stall_cycles, flush_count).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_haz,
    input  logic             branch_taken,
    input  logic             imiss_busy,
    input  logic             dmiss_busy,
    input  logic             halt_FD,
    output logic             pc_we,
    output logic             fd_we,
    output logic             fd_flush,
    output logic             dx_we,
    output logic             dx_bubble,
    output logic             xm_we,
    output logic             mw_we,
    output logic             halted,
`ifdef PIPE_CTRL_PERF_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
`endif
    output logic [1:0]       state_dbg
);

    localparam int CW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    if (DRAIN_CYCLES == 0) begin : gDrainCheck
        $error("pipe_ctrl: DRAIN_CYCLES must be at least 1");
    end
    if (CNT_W < 1) begin : gCntCheck
        $error("pipe_ctrl: CNT_W must be at least 1");
    end

    ctrlState_e    state_r;
    ctrlState_e    nextState_s;
    logic [CW-1:0] drainCnt_r;
    logic [CW-1:0] nextCnt_s;
    logic          halted_r;

    // State, drain counter and halted flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= RUN;
            drainCnt_r <= {CW{1'b0}};
            halted_r   <= 1'b0;
        end else begin
            state_r    <= nextState_s;
            drainCnt_r <= nextCnt_s;
            halted_r   <= (nextState_s == HALTED);
        end
    end

    // Next-state and enable decode; the RUN branches are in priority order
    always_comb begin
        nextState_s = state_r;
        nextCnt_s   = drainCnt_r;
        pc_we       = 1'b0;
        fd_we       = 1'b0;
        fd_flush    = 1'b0;
        dx_we       = 1'b0;
        dx_bubble   = 1'b0;
        xm_we       = 1'b0;
        mw_we       = 1'b0;
        if (rst) begin
            // hold every latch and keep NOPs flowing into IF/ID and ID/EX
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
        end else begin
            case (state_r)
                RUN: begin
                    if (dmiss_busy) begin
                        // MEM cannot complete: freeze everything
                        nextState_s = RUN;
                    end else if (stall_haz) begin
                        dx_we     = 1'b1;
                        dx_bubble = 1'b1;
                        xm_we     = 1'b1;
                        mw_we     = 1'b1;
                    end else if (branch_taken) begin
                        // halt_FD here is on the wrong path
                        pc_we    = 1'b1;
                        fd_we    = 1'b1;
                        fd_flush = 1'b1;
                        dx_we    = 1'b1;
                        xm_we    = 1'b1;
                        mw_we    = 1'b1;
                    end else if (halt_FD) begin
                        fd_we       = 1'b1;
                        fd_flush    = 1'b1;
                        dx_we       = 1'b1;
                        xm_we       = 1'b1;
                        mw_we       = 1'b1;
                        nextState_s = DRAIN;
                        nextCnt_s   = CW'(DRAIN_CYCLES);
                    end else if (imiss_busy) begin
                        fd_we    = 1'b1;
                        fd_flush = 1'b1;
                        dx_we    = 1'b1;
                        xm_we    = 1'b1;
                        mw_we    = 1'b1;
                    end else begin
                        pc_we = 1'b1;
                        fd_we = 1'b1;
                        dx_we = 1'b1;
                        xm_we = 1'b1;
                        mw_we = 1'b1;
                    end
                end
                DRAIN: begin
                    if (dmiss_busy) begin
                        // frozen: counter holds
                        nextCnt_s = drainCnt_r;
                    end else begin
                        fd_we     = 1'b1;
                        fd_flush  = 1'b1;
                        dx_we     = 1'b1;
                        xm_we     = 1'b1;
                        mw_we     = 1'b1;
                        nextCnt_s = drainCnt_r - CW'(1);
                        if (drainCnt_r == CW'(1)) begin
                            nextState_s = HALTED;
                        end else begin
                            nextState_s = DRAIN;
                        end
                    end
                end
                HALTED: begin
                    nextState_s = HALTED;
                end
                default: begin
                    nextState_s = RUN;
                    nextCnt_s   = {CW{1'b0}};
                end
            endcase
        end
    end

    assign halted    = halted_r;
    assign state_dbg = state_r;

`ifdef PIPE_CTRL_PERF_EN
    logic stallInc_s;
    logic flushInc_s;

    assign stallInc_s = (state_r == RUN) && (dmiss_busy || stall_haz || imiss_busy);
    assign flushInc_s = (state_r == RUN) && !dmiss_busy && !stall_haz && branch_taken;

    sat_counter #(.CNT_W(CNT_W)) uStallCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stallInc_s),
        .count (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flushInc_s),
        .count (flush_count)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table of RUN priority vectors plus
// hand-written halt/drain, freeze, reset and (optionally) counter sequences.
// Enable vector bit order: {pc_we, fd_we, fd_flush, dx_we, dx_bubble, xm_we, mw_we}
// Input vector bit order:  {stall_haz, branch_taken, imiss_busy, dmiss_busy, halt_FD}
module tb_pipe_ctrl;

    logic       clk;
    logic       rst;
    logic       stall_haz;
    logic       branch_taken;
    logic       imiss_busy;
    logic       dmiss_busy;
    logic       halt_FD;
    logic       pc_we;
    logic       fd_we;
    logic       fd_flush;
    logic       dx_we;
    logic       dx_bubble;
    logic       xm_we;
    logic       mw_we;
    logic       halted;
    logic [1:0] state_dbg;
`ifdef PIPE_CTRL_PERF_EN
    logic [3:0] stall_cycles;
    logic [3:0] flush_count;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] EN_RST    = 7'b0010100;
    localparam logic [6:0] EN_ALL    = 7'b1101011;
    localparam logic [6:0] EN_NONE   = 7'b0000000;
    localparam logic [6:0] EN_STALL  = 7'b0001111;
    localparam logic [6:0] EN_BRANCH = 7'b1111011;
    localparam logic [6:0] EN_FLUSH  = 7'b0111011;

    typedef struct {
        logic [4:0] in;
        logic [6:0] exp;
        string      name;
    } vec_t;

    vec_t       vecs[10];
    logic [6:0] expQ[$];
    string      nameQ[$];

    pipe_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_haz    (stall_haz),
        .branch_taken (branch_taken),
        .imiss_busy   (imiss_busy),
        .dmiss_busy   (dmiss_busy),
        .halt_FD      (halt_FD),
        .pc_we        (pc_we),
        .fd_we        (fd_we),
        .fd_flush     (fd_flush),
        .dx_we        (dx_we),
        .dx_bubble    (dx_bubble),
        .xm_we        (xm_we),
        .mw_we        (mw_we),
        .halted       (halted),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
`endif
        .state_dbg    (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [4:0] v, input logic [6:0] e, input string nm);
        {stall_haz, branch_taken, imiss_busy, dmiss_busy, halt_FD} = v;
        expQ.push_back(e);
        nameQ.push_back(nm);
    endtask

    task automatic compareOut();
        logic [6:0] e;
        logic [6:0] act;
        string      nm;
        e   = expQ.pop_front();
        nm  = nameQ.pop_front();
        act = {pc_we, fd_we, fd_flush, dx_we, dx_bubble, xm_we, mw_we};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: enables got %b expected %b", nm, act, e);
        end
    endtask

    task automatic checkVal(input string nm, input int act, input int e);
        checks++;
        if (act != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, e);
        end
    endtask

    // Accept HLT, then run the drain; dmiss_busy is asserted for frzLen
    // cycles starting at drain cycle frzStart. expN = cycles until halted.
    task automatic haltRun(input int frzStart, input int frzLen, input int expN, input string nm);
        int   n;
        logic done;
        logic fr;
        n    = 0;
        done = 1'b0;
        @(negedge clk);
        drive(5'b00001, EN_FLUSH, {nm, "_accept"});
        #1 compareOut();
        for (int i = 1; i <= 30; i++) begin
            if (!done) begin
                @(negedge clk);
                if (halted) begin
                    n    = i;
                    done = 1'b1;
                end else begin
                    fr = (i >= frzStart) && (i < frzStart + frzLen);
                    // stall/branch/imiss must all be ignored while draining
                    drive({3'b111, fr, 1'b0}, fr ? EN_NONE : EN_FLUSH, {nm, "_drain"});
                    #1 compareOut();
                    checkVal({nm, "_drain_state"}, int'(state_dbg), 1);
                end
            end
        end
        checkVal({nm, "_latency"}, n, expN);
        checkVal({nm, "_halted_state"}, int'(state_dbg), 2);
    endtask

    initial begin
        vecs[0] = '{5'b00000, EN_ALL,    "run_idle"};
        vecs[1] = '{5'b10010, EN_NONE,   "dmiss_stall"};
        vecs[2] = '{5'b00011, EN_NONE,   "dmiss_halt"};
        vecs[3] = '{5'b11000, EN_STALL,  "stall_branch"};
        vecs[4] = '{5'b10001, EN_STALL,  "stall_halt"};
        vecs[5] = '{5'b01000, EN_BRANCH, "branch"};
        vecs[6] = '{5'b01001, EN_BRANCH, "branch_halt"};
        vecs[7] = '{5'b00100, EN_FLUSH,  "imiss"};
        vecs[8] = '{5'b01100, EN_BRANCH, "imiss_branch"};
        vecs[9] = '{5'b10100, EN_STALL,  "stall_imiss"};

        rst = 1'b1;
        {stall_haz, branch_taken, imiss_busy, dmiss_busy, halt_FD} = 5'b00000;
        repeat (2) @(posedge clk);

        // reset state, with and without inputs asserted
        @(negedge clk);
        drive(5'b00000, EN_RST, "rst_outs");
        #1 compareOut();
        checkVal("rst_halted", int'(halted), 0);
        checkVal("rst_state", int'(state_dbg), 0);
        @(negedge clk);
        drive(5'b11111, EN_RST, "rst_forced");
        #1 compareOut();

        @(negedge clk);
        rst = 1'b0;
        drive(5'b00000, EN_ALL, "release");
        #1 compareOut();

        // RUN priority table
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i].in, vecs[i].exp, vecs[i].name);
            #1 compareOut();
            checkVal({vecs[i].name, "_state"}, int'(state_dbg), 0);
        end

        // unfrozen halt: 3 drain cycles, halted seen on the 4th
        haltRun(100, 0, 4, "halt_plain");
        @(negedge clk);
        drive(5'b11101, EN_NONE, "halted_hold");
        #1 compareOut();
        checkVal("halted_flag", int'(halted), 1);
        @(negedge clk);
        checkVal("halted_sticky", int'(state_dbg), 2);

        // reset from HALTED
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkVal("unhalt_state", int'(state_dbg), 0);
        checkVal("unhalt_flag", int'(halted), 0);

        // 4 frozen cycles mid-drain push halted 4 cycles later
        haltRun(2, 4, 8, "halt_frozen");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // reset mid-drain during a freeze
        @(negedge clk);
        drive(5'b00001, EN_FLUSH, "mid_accept");
        #1 compareOut();
        @(negedge clk);
        rst = 1'b1;
        drive(5'b00010, EN_RST, "mid_rst_forced");
        #1 compareOut();
        @(negedge clk);
        rst = 1'b0;
        checkVal("mid_rst_state", int'(state_dbg), 0);
        checkVal("mid_rst_halted", int'(halted), 0);
        drive(5'b00000, EN_ALL, "mid_rst_run");
        #1 compareOut();

`ifdef PIPE_CTRL_PERF_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkVal("perf_rst_stall", int'(stall_cycles), 0);
        checkVal("perf_rst_flush", int'(flush_count), 0);
        repeat (20) begin
            @(negedge clk);
            drive(5'b00100, EN_FLUSH, "perf_imiss");
            #1 compareOut();
        end
        @(negedge clk);
        drive(5'b01000, EN_BRANCH, "perf_br1");
        #1 compareOut();
        checkVal("perf_stall_sat", int'(stall_cycles), 15);
        @(negedge clk);
        drive(5'b11000, EN_STALL, "perf_br_stalled");
        #1 compareOut();
        @(negedge clk);
        drive(5'b01000, EN_BRANCH, "perf_br2");
        #1 compareOut();
        @(negedge clk);
        drive(5'b00000, EN_ALL, "perf_idle");
        #1 compareOut();
        checkVal("perf_flush_cnt", int'(flush_count), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkVal("perf_clr_stall", int'(stall_cycles), 0);
        checkVal("perf_clr_flush", int'(flush_count), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
